// File: rtl/addsub_cpu.sv
// Minimal 8-bit stack-machine core: PUSH immediate, ADD, SUB and ST0 to reg0.
// One instruction executes per clock edge; there is no fetch handshake.
module addsub_cpu #(
    parameter int STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] insn,
    output logic [7:0]  reg0,
    output logic        reg0_wr
);

    localparam int SP_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);
    localparam logic [SP_W-1:0] SP_TWO = SP_W'(2);

    localparam logic [15:0] OP_ADD = 16'h7001;
    localparam logic [15:0] OP_SUB = 16'h7002;
    localparam logic [15:0] OP_ST0 = 16'h7100;

    logic [7:0]      stack [STACK_DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] tos_idx;
    logic [SP_W-1:0] nos_idx;
    logic [7:0]      tos;
    logic [7:0]      nos;
    logic            is_push;
    logic            is_add;
    logic            is_sub;
    logic            is_st0;

    function automatic logic [7:0] wrap_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    function automatic logic [7:0] wrap_sub(input logic [7:0] a, input logic [7:0] b);
        return a - b;
    endfunction

    // Index arithmetic wraps naturally in SP_W bits, giving the circular stack.
    assign tos_idx = sp - SP_ONE;
    assign nos_idx = sp - SP_TWO;
    assign tos     = stack[tos_idx];
    assign nos     = stack[nos_idx];

    always_comb begin
        is_push = 1'b0;
        is_add  = 1'b0;
        is_sub  = 1'b0;
        is_st0  = 1'b0;
        if (insn[15])
            is_push = 1'b1;
        else if (insn == OP_ADD)
            is_add = 1'b1;
        else if (insn == OP_SUB)
            is_sub = 1'b1;
        else if (insn == OP_ST0)
            is_st0 = 1'b1;
    end

    // Execute stage: every instruction retires on the edge that samples it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp      <= '0;
            reg0    <= '0;
            reg0_wr <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++)
                stack[i] <= '0;
        end else begin
            reg0_wr <= 1'b0;
            if (is_push) begin
                stack[sp] <= insn[7:0];
                sp        <= sp + SP_ONE;
            end else if (is_add) begin
                stack[nos_idx] <= wrap_add(nos, tos);
                sp             <= tos_idx;
            end else if (is_sub) begin
                stack[nos_idx] <= wrap_sub(nos, tos);
                sp             <= tos_idx;
            end else if (is_st0) begin
                reg0    <= tos;
                reg0_wr <= 1'b1;
                sp      <= tos_idx;
            end
        end
    end

endmodule

// File: tb/tb_addsub_cpu.sv
// Self-checking bench for addsub_cpu: directed programs plus random instruction
// streams compared against a behavioural stack-machine model.
module tb_addsub_cpu;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic [15:0] insn;
    logic [7:0]  reg0;
    logic        reg0_wr;

    int vectors;
    int miscompares;

    // Reference model state: live values kept in a plain array indexed modulo DEPTH.
    int unsigned m_mem [DEPTH];
    int          m_sp;
    int unsigned m_reg0;
    bit          m_wr;

    addsub_cpu #(.STACK_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .insn    (insn),
        .reg0    (reg0),
        .reg0_wr (reg0_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int wrapi(input int i);
        return ((i % DEPTH) + DEPTH) % DEPTH;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_sp   = 0;
        m_reg0 = 0;
        m_wr   = 0;
    endfunction

    function automatic void model_exec(input logic [15:0] op);
        int unsigned a, b;
        m_wr = 0;
        a = m_mem[wrapi(m_sp - 2)];
        b = m_mem[wrapi(m_sp - 1)];
        if (op[15]) begin
            m_mem[wrapi(m_sp)] = op & 16'h00FF;
            m_sp = wrapi(m_sp + 1);
        end else if (op == 16'h7001) begin
            m_mem[wrapi(m_sp - 2)] = (a + b) % 256;
            m_sp = wrapi(m_sp - 1);
        end else if (op == 16'h7002) begin
            m_mem[wrapi(m_sp - 2)] = (a + 256 - b) % 256;
            m_sp = wrapi(m_sp - 1);
        end else if (op == 16'h7100) begin
            m_reg0 = b;
            m_wr   = 1;
            m_sp   = wrapi(m_sp - 1);
        end
    endfunction

    // Apply one cycle with the given rst/insn, then compare against the model.
    task automatic step(input logic r, input logic [15:0] op);
        rst  = r;
        insn = op;
        @(posedge clk);
        #1;
        if (!r) model_reset();
        else    model_exec(op);
        chk("reg0", reg0, m_reg0[7:0]);
        chk("reg0_wr", {7'd0, reg0_wr}, {7'd0, m_wr});
    endtask

    task automatic run(input logic [15:0] ops []);
        foreach (ops[i]) step(1'b1, ops[i]);
    endtask

    initial begin
        logic [15:0] op;
        int          sel;
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b0;
        insn = 16'h0000;
        model_reset();

        // Reset held with a push pending; pushes must be discarded.
        step(1'b0, 16'h8055);
        step(1'b0, 16'h8055);
        chk("rst_reg0", reg0, 8'h00);
        chk("rst_wr", {7'd0, reg0_wr}, 8'h00);
        step(1'b1, 16'h7100);
        chk("rst_st0", reg0, 8'h00);

        run('{16'h8003, 16'h8004, 16'h7001, 16'h7100});
        chk("add", reg0, 8'h07);
        chk("add_wr", {7'd0, reg0_wr}, 8'h01);
        step(1'b1, 16'h0000);
        chk("add_wr_clear", {7'd0, reg0_wr}, 8'h00);

        run('{16'h8005, 16'h8007, 16'h7002, 16'h7100});
        chk("sub_borrow", reg0, 8'hFE);
        run('{16'h8009, 16'h8002, 16'h7002, 16'h7100});
        chk("sub_order", reg0, 8'h07);

        run('{16'h80FF, 16'h8102, 16'h7001, 16'h7100});
        chk("add_ovf", reg0, 8'h01);

        run('{16'h800A, 16'h8003, 16'h8002, 16'h7002, 16'h7002, 16'h7100});
        chk("nested", reg0, 8'h09);
        run('{16'h800A, 16'h0000, 16'h8003, 16'h1234, 16'h8002, 16'h0000,
              16'h7002, 16'h1234, 16'h7002, 16'h0000, 16'h7100});
        chk("nested_nop", reg0, 8'h09);

        // Wrap: 17 pushes overwrite slot 0, then drain.
        step(1'b0, 16'h0000);
        for (int i = 1; i <= 17; i++) step(1'b1, 16'h8000 | 16'(i));
        step(1'b1, 16'h7100);
        chk("wrap_first", reg0, 8'h11);
        for (int i = 0; i < 15; i++) step(1'b1, 16'h7100);
        chk("wrap_drain", reg0, 8'h02);
        chk("wrap_b2b_wr", {7'd0, reg0_wr}, 8'h01);
        step(1'b1, 16'h7100);
        chk("wrap_over", reg0, 8'h11);

        run('{16'h8033, 16'h8044});
        step(1'b0, 16'h7100);
        step(1'b1, 16'h7100);
        chk("mid_rst", reg0, 8'h00);

        // Random instruction stream, occasional reset.
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 40)      op = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            else if (sel < 58) op = 16'h7001;
            else if (sel < 74) op = 16'h7002;
            else if (sel < 90) op = 16'h7100;
            else               op = 16'($urandom_range(0, 16'h7FFF));
            step((sel == 99) ? 1'b0 : 1'b1, op);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
